// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package mul_pkg;

  localparam int MUL_N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier.
// The 2N-bit adder lives outside this block: each CALC cycle the partial sum
// is presented on alu_a/alu_b and the sum comes back combinationally on alu_sum.
// Optional feature: define MUL_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero instead of always running N cycles.
//
// Handshake: start is sampled only while ready is high (state IDLE); an
// accepted start captures both operands on that edge, later operand changes
// are ignored. done is a one-cycle pulse in which product already holds the
// new result; product then holds until the next accepted start completes.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int N = MUL_N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product,
  output logic [2*N-1:0]   alu_a,
  output logic [2*N-1:0]   alu_b,
  input  logic [2*N-1:0]   alu_sum,
  output mul_state_t       o_dbg_state
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mul_state_t         r_state;
  logic [2*N-1:0]     r_mcand;
  logic [N-1:0]       r_mplier;
  logic [2*N-1:0]     r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*N-1:0]     r_product;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               w_term;

  // Termination: the last of N iterations, or (optionally) no set bits left.
`ifdef MUL_EARLY_TERM_EN
  assign w_term = (r_cnt == CNT_LAST) || ((r_mplier >> 1) == '0);
`else
  assign w_term = (r_cnt == CNT_LAST);
`endif

  // Adder operands: partial sum plus the shifted multiplicand when the
  // current multiplier bit is set; quiet (zero) outside CALC.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (r_state == CALC) begin
      alu_a = r_acc;
      alu_b = r_mplier[0] ? r_mcand : '0;
    end
  end

  // FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{N{1'b0}}, multiplicand};
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= CALC;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        CALC: begin
          r_acc    <= alu_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_term) begin
            r_product <= alu_sum;
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign product     = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=32). The external adder is
// modelled here as a plain combinational sum. Builds with or without
// MUL_EARLY_TERM_EN; the reference model follows the same define.
module tb_shift_add_multiplier;
  import mul_pkg::*;

  localparam int N = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [N-1:0]     mc;
  logic [N-1:0]     mp;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;
  logic [2*N-1:0]   alu_a;
  logic [2*N-1:0]   alu_b;
  logic [2*N-1:0]   alu_sum;
  mul_state_t       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*N-1:0] exp_q[$];

  shift_add_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sum      (alu_sum),
    .o_dbg_state  (dbg_state)
  );

  assign alu_sum = alu_a + alu_b;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*N-1:0] model_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] wa;
    logic [2*N-1:0] wb;
    wa = {{N{1'b0}}, a};
    wb = {{N{1'b0}}, b};
    return wa * wb;
  endfunction

  function automatic int model_calc_cycles(input logic [N-1:0] b);
    int bl;
    bl = 0;
    for (int i = 0; i < N; i++) if (b[i]) bl = i + 1;
`ifdef MUL_EARLY_TERM_EN
    return (bl < 1) ? 1 : bl;
`else
    return N;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Wait for IDLE, present operands for one edge, then scramble them.
  task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 200) begin
      bad++;
      $display("FAIL start_wait: ready never rose, waited=%0d limit=200", w);
    end
    start = 1'b1;
    mc    = a;
    mp    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model_mul(a, b));
    mc = $urandom;
    mp = $urandom;
  endtask

  // Observe cycles after the start edge until done (bounded).
  task automatic wait_done(output bit seen, output int idx, output int calc, output int nz);
    seen = 1'b0;
    idx  = 0;
    calc = 0;
    nz   = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (busy) begin
        calc++;
        if (alu_b !== '0) nz++;
      end
      if (done) begin
        seen = 1'b1;
        idx  = i;
        break;
      end
    end
  endtask

  function automatic logic [2*N-1:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mc = '0; mp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: ready/busy/done=%b%b%b expected 100", ready, busy, done);
    end
    total++;
    if (product !== '0 || alu_a !== '0 || alu_b !== '0) begin
      bad++;
      $display("FAIL reset_data: product=%h alu_a=%h alu_b=%h expected all 0", product, alu_a, alu_b);
    end
    // reset wins over start
    start = 1'b1; mc = 32'd3; mp = 32'd5;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_priority: busy=%b ready=%b expected 0 1", busy, ready);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_basic();
    bit seen; int idx, calc, nz;
    logic [2*N-1:0] e;
    drive_start(32'd3, 32'd5);
    wait_done(seen, idx, calc, nz);
    e = pop_exp();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL basic_done: done not seen within 200 cycles");
    end
    total++;
    if (idx != model_calc_cycles(32'd5) + 1) begin
      bad++;
      $display("FAIL basic_latency: done at k+%0d expected k+%0d", idx, model_calc_cycles(32'd5) + 1);
    end
    total++;
    if (product !== 64'h000000000000000F || product !== e) begin
      bad++;
      $display("FAIL basic_product: got %h expected %h", product, 64'h000000000000000F);
    end
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || alu_a !== '0 || alu_b !== '0) begin
      bad++;
      $display("FAIL basic_after: ready=%b done=%b alu_a=%h alu_b=%h expected 1 0 0 0", ready, done, alu_a, alu_b);
    end
  endtask

  task automatic test_max();
    bit seen; int idx, calc, nz;
    logic [2*N-1:0] e;
    drive_start('1, '1);
    wait_done(seen, idx, calc, nz);
    e = pop_exp();
    total++;
    if (!seen || product !== 64'hFFFFFFFE00000001 || product !== e) begin
      bad++;
      $display("FAIL max_product: seen=%0d got %h expected %h", seen, product, 64'hFFFFFFFE00000001);
    end
    total++;
    if (nz != N || calc != N) begin
      bad++;
      $display("FAIL max_alu_b: nonzero=%0d calc=%0d expected %0d %0d", nz, calc, N, N);
    end
  endtask

  task automatic test_early_term();
    bit seen; int idx, calc, nz;
    logic [2*N-1:0] e;
    logic [N-1:0] av [2];
    logic [N-1:0] bv [2];
    av[0] = 32'd7; bv[0] = 32'd5;
    av[1] = 32'd9; bv[1] = 32'd0;
    for (int t = 0; t < 2; t++) begin
      drive_start(av[t], bv[t]);
      wait_done(seen, idx, calc, nz);
      e = pop_exp();
      total++;
      if (!seen || product !== e) begin
        bad++;
        $display("FAIL early_product[%0d]: seen=%0d got %h expected %h", t, seen, product, e);
      end
      total++;
      if (calc != model_calc_cycles(bv[t]) || idx != calc + 1) begin
        bad++;
        $display("FAIL early_cycles[%0d]: calc=%0d done_at=k+%0d expected calc=%0d", t, calc, idx, model_calc_cycles(bv[t]));
      end
    end
  endtask

  task automatic test_random();
    bit seen; int idx, calc, nz;
    logic [2*N-1:0] e;
    logic [N-1:0] a, b;
    int errs;
    errs = 0;
    for (int t = 0; t < 24; t++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      drive_start(a, b);
      wait_done(seen, idx, calc, nz);
      e = pop_exp();
      total++;
      if (!seen || product !== e) begin
        bad++;
        $display("FAIL rand_product[%0d]: a=%h b=%h got %h expected %h", t, a, b, product, e);
      end
      total++;
      if (calc != model_calc_cycles(b) || idx != calc + 1) begin
        bad++;
        $display("FAIL rand_cycles[%0d]: b=%h calc=%0d expected %0d", t, b, calc, model_calc_cycles(b));
      end
    end
  endtask

  task automatic test_ignore_start();
    bit seen; int idx, calc, nz;
    logic [2*N-1:0] e;
    int extra_done, extra_busy;
    drive_start(32'h01234567, 32'h89ABCDEF);
    repeat (3) @(negedge clk);
    start = 1'b1; mc = 32'd2; mp = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen, idx, calc, nz);
    e = pop_exp();
    total++;
    if (!seen || product !== e) begin
      bad++;
      $display("FAIL ignore_product: seen=%0d got %h expected %h", seen, product, e);
    end
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    total++;
    if (extra_done != 0 || extra_busy != 0 || product !== e) begin
      bad++;
      $display("FAIL ignore_extra: done_pulses=%0d busy_cycles=%0d product=%h expected 0 0 %h", extra_done, extra_busy, product, e);
    end
  endtask

  task automatic test_abort();
    bit seen; int idx, calc, nz;
    logic [2*N-1:0] e;
    int n_calc, w, dones;
    drive_start(32'h0000DEAD, 32'h80000001);
    n_calc = 0; w = 0;
    while (n_calc < 10 && w < 40) begin
      @(negedge clk);
      w++;
      if (busy) n_calc++;
    end
    total++;
    if (n_calc != 10) begin
      bad++;
      $display("FAIL abort_reach: calc cycles seen=%0d expected 10", n_calc);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    dones = 0;
    @(negedge clk);
    total++;
    if (product !== '0 || ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: product=%h ready=%b busy=%b expected 0 1 0", product, ready, busy);
    end
    if (done) dones++;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_done: done pulses=%0d expected 0", dones);
    end
    drive_start(32'hCAFE1234, 32'h00ABCDEF);
    wait_done(seen, idx, calc, nz);
    e = pop_exp();
    total++;
    if (!seen || product !== e) begin
      bad++;
      $display("FAIL abort_recover: seen=%0d got %h expected %h", seen, product, e);
    end
  endtask

  task automatic test_back_to_back();
    bit seen; int idx, calc, nz;
    logic [2*N-1:0] e;
    logic [N-1:0] a1, b1, a2, b2;
    int w;
    a1 = $urandom; b1 = $urandom | 32'h00010000;
    a2 = $urandom; b2 = $urandom >> $urandom_range(0, 20);
    @(negedge clk);
    w = 0;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    start = 1'b1; mc = a1; mp = b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model_mul(a1, b1));
    mc = a2; mp = b2;
    wait_done(seen, idx, calc, nz);
    e = pop_exp();
    total++;
    if (!seen || product !== e || calc != model_calc_cycles(b1)) begin
      bad++;
      $display("FAIL b2b_first: seen=%0d got %h expected %h calc=%0d", seen, product, e, calc);
    end
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: ready=%b busy=%b expected 1 0", ready, busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model_mul(a2, b2));
    mc = $urandom; mp = $urandom;
    wait_done(seen, idx, calc, nz);
    e = pop_exp();
    total++;
    if (!seen || product !== e) begin
      bad++;
      $display("FAIL b2b_second: seen=%0d got %h expected %h", seen, product, e);
    end
    total++;
    if (calc != model_calc_cycles(b2) || idx != calc + 1) begin
      bad++;
      $display("FAIL b2b_cycles: calc=%0d done_at=k+%0d expected calc=%0d", calc, idx, model_calc_cycles(b2));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; mc = '0; mp = '0;
    test_reset();
    test_basic();
    test_max();
    test_early_term();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case something blocks outside the bounded waits
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
